// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the Wishbone initiator and its helpers
package wb_pkg;

  localparam int WB_TMO_CNT_W = 16;
  localparam int WB_AW        = 32;
  localparam int WB_DW        = 32;

  typedef enum logic [1:0] {
    WB_M_IDLE,
    WB_M_BUS,
    WB_M_RESP
  } wb_m_state_t;

  typedef struct packed {
    logic [WB_AW-1:0]   addr;
    logic [WB_DW-1:0]   wdata;
    logic               we;
    logic [WB_DW/8-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/wb_master_port_if.sv
// rtl/wb_master_port_if.sv - client request/response channels plus the Wishbone initiator bus
interface wb_master_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic            req_valid_i;
  logic            req_ready_o;
  logic [AW-1:0]   req_addr_i;
  logic [DW-1:0]   req_wdata_i;
  logic            req_we_i;
  logic [DW/8-1:0] req_sel_i;

  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [DW-1:0]   resp_rdata_o;
  logic            resp_err_o;
  logic            resp_tmo_o;

  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_wdata_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0]   wb_rdata_i;
  logic            wb_ack_i;
  logic            wb_err_i;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_sel_i, resp_ready_i,
           wb_rdata_i, wb_ack_i, wb_err_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_tmo_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_wdata_o, wb_sel_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_sel_i, resp_ready_i,
           wb_rdata_i, wb_ack_i, wb_err_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_tmo_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_wdata_o, wb_sel_o
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - saturating abort timer; expired once LIMIT-1 cycles have been counted
module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int W     = WB_TMO_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned LIMIT_M1 = (LIMIT > 0) ? LIMIT - 1 : 0;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // LIMIT of 0 disables the abort entirely
  assign expired_o = (LIMIT > 0) && (32'(cnt_q) >= LIMIT_M1);

endmodule

// File: rtl/wb_master_port.sv
// rtl/wb_master_port.sv - single-transfer Wishbone classic initiator with timeout abort
module wb_master_port
  import wb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  wb_master_port_if.master bus
);

  localparam int SW = WB_DATA_WIDTH / 8;

  wb_m_state_t              state_q;
  logic                     cyc_q;
  logic                     we_q;
  logic [WB_ADDR_WIDTH-1:0] addr_q;
  logic [WB_DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]            sel_q;
  logic                     resp_valid_q;
  logic [WB_DATA_WIDTH-1:0] rdata_q;
  logic                     err_q;
  logic                     tmo_q;

  logic accept;
  logic tmo_expired;

  assign bus.req_ready_o = (state_q == WB_M_IDLE) && en_i && !rst_i;
  assign accept          = (state_q == WB_M_IDLE) && en_i && bus.req_valid_i;

  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (WB_TMO_CNT_W)
  ) u_tmo (
    .clk_i     (wb_clk_i),
    .rst_i     (rst_i),
    .clear_i   (accept),
    .en_i      (state_q == WB_M_BUS),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge wb_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= WB_M_IDLE;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      case (state_q)
        WB_M_IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i;
            we_q    <= bus.req_we_i;
            sel_q   <= bus.req_sel_i;
            cyc_q   <= 1'b1;
            state_q <= WB_M_BUS;
          end
        end
        WB_M_BUS: begin
          // a bus termination beats a simultaneous timeout; err beats ack
          if (bus.wb_ack_i || bus.wb_err_i) begin
            cyc_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            rdata_q      <= (bus.wb_ack_i && !bus.wb_err_i && !we_q) ? bus.wb_rdata_i : '0;
            err_q        <= bus.wb_err_i;
            tmo_q        <= 1'b0;
            state_q      <= WB_M_RESP;
          end else if (tmo_expired) begin
            cyc_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            rdata_q      <= '0;
            err_q        <= 1'b1;
            tmo_q        <= 1'b1;
            state_q      <= WB_M_RESP;
          end
        end
        WB_M_RESP: begin
          if (bus.resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= WB_M_IDLE;
          end
        end
        default: begin
          cyc_q        <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= WB_M_IDLE;
        end
      endcase
    end
  end

  assign bus.wb_cyc_o     = cyc_q;
  assign bus.wb_stb_o     = cyc_q;
  assign bus.wb_we_o      = we_q;
  assign bus.wb_addr_o    = addr_q;
  assign bus.wb_wdata_o   = wdata_q;
  assign bus.wb_sel_o     = sel_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = rdata_q;
  assign bus.resp_err_o   = err_q;
  assign bus.resp_tmo_o   = tmo_q;

endmodule
